alu_issue_ctrl: RTL and testbench

Sequential issue/writeback stage wrapped around the 8-bit combinational ALU (ops 0000–1010, flags C/V/Z/N).
- Accepts register-to-register commands over a valid/ready handshake and holds an 8-entry x 8-bit register file.
- Drives registered operands and select into the ALU, captures result and flags, writes back to the destination register and a sticky flags register.
- Sits between the command source and the ALU, feeding it and consuming what it produces.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_regfile.sv | 35 +++
 rtl/alu_issue_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and FSM encoding for the ALU issue stage.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_XOR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_SHR = 4'b1001;
    localparam logic [3:0] OP_NOT = 4'b1010;
    localparam logic [3:0] OP_LDI = 4'b1111;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_EXEC = 2'd2;
    localparam logic [1:0] ST_WB   = 2'd3;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// NREGS x 8 register file: one write port, two operand reads, one debug read.
module alu_regfile #(
    parameter int NREGS = 8,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [7:0]    wd,
    input  logic [AW-1:0] ra_addr,
    output logic [7:0]    ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [7:0]    rb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    logic [7:0] mem [NREGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage: reads operands, drives the external ALU,
// captures its result and flags, writes back to the register file.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int         NREGS  = 8,
    parameter int         AW     = $clog2(NREGS),
    parameter logic [3:0] LDI_OP = OP_LDI
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_rd,
    input  logic [AW-1:0] cmd_ra,
    input  logic [AW-1:0] cmd_rb,
    input  logic [7:0]    cmd_imm,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic [3:0]    alu_select,
    input  logic [7:0]    alu_result,
    input  logic          alu_carry,
    input  logic          alu_overflow,
    input  logic          alu_zero,
    input  logic          alu_negative,
    output logic [3:0]    flags,
    output logic          done,
    output logic          err,
    input  logic [AW-1:0] dbg_addr,
    output logic [7:0]    dbg_data
);

    logic [1:0]    state;
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] ra_q;
    logic [AW-1:0] rb_q;
    logic [7:0]    imm_q;
    logic [7:0]    res_q;
    logic [3:0]    flag_q;
    logic          err_q;

    logic          xfer;
    logic          op_is_ldi;
    logic          rf_we;
    logic [7:0]    rf_wd;
    logic [7:0]    ra_data;
    logic [7:0]    rb_data;
    logic [3:0]    alu_flags;

    assign cmd_ready = (state == ST_IDLE);
    assign xfer      = cmd_valid && cmd_ready;
    assign op_is_ldi = (op_q == LDI_OP);
    assign done      = (state == ST_WB);
    assign err       = err_q;
    assign rf_we     = (state == ST_WB);
    assign rf_wd     = op_is_ldi ? imm_q : res_q;

    always_comb begin
        alu_flags         = 4'b0000;
        alu_flags[FLAG_C] = alu_carry;
        alu_flags[FLAG_V] = alu_overflow;
        alu_flags[FLAG_Z] = alu_zero;
        alu_flags[FLAG_N] = alu_negative;
    end

    alu_regfile #(
        .NREGS(NREGS),
        .AW   (AW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .wa      (rd_q),
        .wd      (rf_wd),
        .ra_addr (ra_q),
        .ra_data (ra_data),
        .rb_addr (rb_q),
        .rb_data (rb_data),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= 4'h0;
            rd_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            imm_q      <= 8'h00;
            res_q      <= 8'h00;
            flag_q     <= 4'h0;
            flags      <= 4'h0;
            err_q      <= 1'b0;
            alu_a      <= 8'h00;
            alu_b      <= 8'h00;
            alu_select <= 4'h0;
        end else begin
            err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        op_q  <= cmd_op;
                        rd_q  <= cmd_rd;
                        ra_q  <= cmd_ra;
                        rb_q  <= cmd_rb;
                        imm_q <= cmd_imm;
                        if (is_alu_op(cmd_op) || cmd_op == LDI_OP) begin
                            state <= ST_READ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    alu_a      <= ra_data;
                    alu_b      <= rb_data;
                    alu_select <= op_q;
                    state      <= op_is_ldi ? ST_WB : ST_EXEC;
                end
                ST_EXEC: begin
                    res_q  <= alu_result;
                    flag_q <= alu_flags;
                    state  <= ST_WB;
                end
                ST_WB: begin
                    // LDI bypasses the ALU, so it must not disturb the sticky flags
                    if (!op_is_ldi) begin
                        flags <= flag_q;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU on the alu_* bus plus a
// register-file/flags reference model driven by directed and random commands.
module tb_alu_issue_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [2:0] cmd_rd;
    logic [2:0] cmd_ra;
    logic [2:0] cmd_rb;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_select;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       alu_zero;
    logic       alu_negative;
    logic [3:0] flags;
    logic       done;
    logic       err;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_rf [8];
    logic [3:0] m_flags;

    alu_issue_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_ra      (cmd_ra),
        .cmd_rb      (cmd_rb),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_select  (alu_select),
        .alu_result  (alu_result),
        .alu_carry   (alu_carry),
        .alu_overflow(alu_overflow),
        .alu_zero    (alu_zero),
        .alu_negative(alu_negative),
        .flags       (flags),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // returns {C,V,Z,N,result}
    function automatic logic [11:0] alu_ref(input logic [3:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        logic        c;
        logic        v;
        s = '0; p = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[7:0]; c = s[8];
                v = (a[7] == b[7]) && (r[7] != a[7]);
            end
            4'd1: begin
                r = a - b; c = (a < b);
                v = (a[7] != b[7]) && (r[7] != a[7]);
            end
            4'd2: begin
                p = 16'(a) * 16'(b);
                r = p[7:0]; c = |p[15:8];
            end
            4'd3: r = (b == 8'd0) ? 8'd0 : a / b;
            4'd4: r = (b == 8'd0) ? 8'd0 : a % b;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: begin r = {a[6:0], 1'b0}; c = a[7]; end
            4'd9: begin r = {1'b0, a[7:1]}; c = a[0]; end
            4'd10: r = ~a;
            default: r = 8'd0;
        endcase
        return {c, v, (r == 8'd0), r[7], r};
    endfunction

    always_comb begin
        {alu_carry, alu_overflow, alu_zero, alu_negative, alu_result} =
            alu_ref(alu_select, alu_a, alu_b);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            chk(tag, 32'(dbg_data), 32'(m_rf[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        m_flags = 4'h0;
    endtask

    task automatic scramble_cmd();
        cmd_op  = 4'($urandom);
        cmd_rd  = 3'($urandom);
        cmd_ra  = 3'($urandom);
        cmd_rb  = 3'($urandom);
        cmd_imm = 8'($urandom);
    endtask

    task automatic do_cmd(input logic [3:0] op, input logic [2:0] rd,
                          input logic [2:0] ra, input logic [2:0] rb,
                          input logic [7:0] imm);
        logic [11:0] e;
        logic        is_alu;
        logic        is_ldi;
        int          lat;
        is_alu = (op <= 4'd10);
        is_ldi = (op == 4'd15);
        @(negedge clk);
        cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        cmd_valid = 1'b1;
        chk("ready_idle", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble_cmd();
        if (!is_alu && !is_ldi) begin
            @(negedge clk);
            chk("err_pulse", 32'(err), 1);
            chk("err_ready", 32'(cmd_ready), 1);
            chk("err_done", 32'(done), 0);
            @(negedge clk);
            chk("err_clear", 32'(err), 0);
            chk("err_flags", 32'(flags), 32'(m_flags));
            check_all_regs("err_rf");
            return;
        end
        e   = alu_ref(op, m_rf[ra], m_rf[rb]);
        lat = is_alu ? 3 : 2;
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("busy_ready", 32'(cmd_ready), 0);
            chk("busy_done", 32'(done), 0);
            chk("busy_err", 32'(err), 0);
            if (is_alu && k == 2) begin
                chk("exec_a", 32'(alu_a), 32'(m_rf[ra]));
                chk("exec_b", 32'(alu_b), 32'(m_rf[rb]));
                chk("exec_sel", 32'(alu_select), 32'(op));
            end
        end
        @(negedge clk);
        chk("wb_done", 32'(done), 1);
        chk("wb_ready", 32'(cmd_ready), 0);
        chk("wb_err", 32'(err), 0);
        if (is_alu) begin
            m_rf[rd] = e[7:0];
            m_flags  = e[11:8];
        end else begin
            m_rf[rd] = imm;
        end
        @(negedge clk);
        chk("post_done", 32'(done), 0);
        chk("post_ready", 32'(cmd_ready), 1);
        dbg_addr = rd;
        #1;
        chk("rd_value", 32'(dbg_data), 32'(m_rf[rd]));
        chk("flags", 32'(flags), 32'(m_flags));
    endtask

    task automatic peek(input string tag, input logic [2:0] r,
                        input logic [7:0] v, input logic [3:0] f);
        dbg_addr = r;
        #1;
        chk(tag, 32'(dbg_data), 32'(v));
        chk({tag, "_flags"}, 32'(flags), 32'(f));
    endtask

    task automatic back_to_back();
        logic [3:0] q_op [3];
        logic [2:0] q_rd [3];
        logic [2:0] q_ra [3];
        logic [2:0] q_rb [3];
        logic [11:0] e;
        logic rdy;
        int idx, cyc, last, ndone;
        q_op[0] = 4'd0; q_rd[0] = 3'd2; q_ra[0] = 3'd1; q_rb[0] = 3'd1;
        q_op[1] = 4'd7; q_rd[1] = 3'd3; q_ra[1] = 3'd2; q_rb[1] = 3'd1;
        q_op[2] = 4'd1; q_rd[2] = 3'd4; q_ra[2] = 3'd3; q_rb[2] = 3'd2;
        idx = 0; cyc = 0; last = 0; ndone = 0;
        @(negedge clk);
        cmd_op = q_op[0]; cmd_rd = q_rd[0];
        cmd_ra = q_ra[0]; cmd_rb = q_rb[0]; cmd_imm = 8'h00;
        cmd_valid = 1'b1;
        while (idx < 3 && cyc < 40) begin
            if (idx > 0 && (cyc - last) < 4)
                chk("b2b_busy", 32'(cmd_ready), 0);
            if (done) ndone++;
            rdy = cmd_ready;
            @(posedge clk);
            if (rdy) begin
                if (idx > 0) chk("b2b_gap", 32'(cyc - last), 4);
                last = cyc;
                e = alu_ref(q_op[idx], m_rf[q_ra[idx]], m_rf[q_rb[idx]]);
                m_rf[q_rd[idx]] = e[7:0];
                m_flags = e[11:8];
                idx++;
                #1;
                if (idx < 3) begin
                    cmd_op = q_op[idx]; cmd_rd = q_rd[idx];
                    cmd_ra = q_ra[idx]; cmd_rb = q_rb[idx];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        chk("b2b_count", 32'(idx), 3);
        for (int k = 0; k < 5; k++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("b2b_dones", 32'(ndone), 3);
        chk("b2b_flags", 32'(flags), 32'(m_flags));
        check_all_regs("b2b_rf");
    endtask

    task automatic reset_in_exec();
        int nd;
        @(negedge clk);
        cmd_op = 4'd0; cmd_rd = 3'd5; cmd_ra = 3'd1; cmd_rb = 3'd2;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_flags", 32'(flags), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) nd++;
            @(negedge clk);
        end
        chk("rst_no_done", 32'(nd), 0);
        chk("rst_ready_after", 32'(cmd_ready), 1);
        chk("rst_alu_sel", 32'(alu_select), 0);
        check_all_regs("rst_rf_after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        dbg_addr = 3'd0;
        scramble_cmd();
        model_reset();
        #12;
        chk("reset_ready", 32'(cmd_ready), 1);
        chk("reset_done", 32'(done), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_flags", 32'(flags), 0);
        chk("reset_alu_a", 32'(alu_a), 0);
        chk("reset_alu_b", 32'(alu_b), 0);
        @(negedge clk);
        rst = 1'b0;
        check_all_regs("reset_rf");

        do_cmd(4'd15, 3'd1, 3'd0, 3'd0, 8'h7F);
        do_cmd(4'd15, 3'd2, 3'd0, 3'd0, 8'h01);
        do_cmd(4'd0, 3'd3, 3'd1, 3'd2, 8'h00);
        peek("add_7f_01", 3'd3, 8'h80, 4'b0101);

        do_cmd(4'd15, 3'd4, 3'd0, 3'd0, 8'h00);
        do_cmd(4'd15, 3'd5, 3'd0, 3'd0, 8'h01);
        do_cmd(4'd1, 3'd6, 3'd4, 3'd5, 8'h00);
        peek("sub_0_1", 3'd6, 8'hFF, 4'b1001);

        do_cmd(4'd15, 3'd7, 3'd0, 3'd0, 8'h55);
        do_cmd(4'd3, 3'd0, 3'd7, 3'd4, 8'h00);
        peek("div_by_0", 3'd0, 8'h00, 4'b0010);

        do_cmd(4'd15, 3'd0, 3'd0, 3'd0, 8'h3C);
        peek("ldi_keeps_flags", 3'd0, 8'h3C, 4'b0010);

        do_cmd(4'd12, 3'd1, 3'd2, 3'd3, 8'hAA);
        do_cmd(4'd0, 3'd1, 3'd1, 3'd1, 8'h00);

        do_cmd(4'd15, 3'd1, 3'd0, 3'd0, 8'h13);
        back_to_back();

        for (int n = 0; n < 40; n++) begin
            do_cmd(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom),
                   3'($urandom), 8'($urandom));
        end
        check_all_regs("rand_rf");

        reset_in_exec();

        do_cmd(4'd15, 3'd2, 3'd0, 3'd0, 8'hC3);
        do_cmd(4'd10, 3'd3, 3'd2, 3'd2, 8'h00);
        peek("not_after_rst", 3'd3, 8'h3C, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
